// File: rtl/fb_ram_ctl.sv
// fb_ram_ctl: single-clock dual-port frame-buffer RAM.
// Capture side writes through a per-lane masked port, the VGA scan side
// reads with 1 or 2 cycles of latency, and a clear sequencer blanks the
// whole buffer between frames by stealing the write port.
module fb_ram_ctl #(
  parameter int                    ADDR_WIDTH  = 14,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    LANES       = 1,
  parameter int                    RD_LATENCY  = 1,
  parameter int                    BYPASS      = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [LANES-1:0]      wr_mask,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int LANE_W = DATA_WIDTH / LANES;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] CNT_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [LANES-1:0]      MASK_ALL = {LANES{1'b1}};

  // Replace the lanes selected by mask with new_w, keep old_w elsewhere.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [LANES-1:0]      mask
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = old_w;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) begin
        merged[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
      end else begin
        merged[i*LANE_W +: LANE_W] = old_w[i*LANE_W +: LANE_W];
      end
    end
    return merged;
  endfunction

  // Storage: deliberately not reset, contents are undefined after power-up.
  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic [ADDR_WIDTH-1:0] cnt_nxt_s;
  logic                  wr_ready_r;
  logic                  clear_busy_r;
  logic                  clear_done_r;

  logic                  we_s;
  logic [ADDR_WIDTH-1:0] wa_s;
  logic [DATA_WIDTH-1:0] wd_s;
  logic [LANES-1:0]      wm_s;

  logic [DATA_WIDTH-1:0] rd_old_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;

  // Clear sequencer next-state and address counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (clear_start) begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = cnt_r;
        end
      end
      ST_CLEAR: begin
        cnt_nxt_s = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Sequencer state plus status outputs decoded from the next state so
  // they are registered yet line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      wr_ready_r   <= 1'b1;
      clear_busy_r <= 1'b0;
      clear_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      wr_ready_r   <= (state_nxt_s != ST_CLEAR);
      clear_busy_r <= (state_nxt_s == ST_CLEAR);
      clear_done_r <= (state_nxt_s == ST_DONE);
    end
  end

  assign wr_ready   = wr_ready_r;
  assign clear_busy = clear_busy_r;
  assign clear_done = clear_done_r;

  // Write port mux: the sequencer owns the port while clearing and any
  // external write in that window is simply dropped.
  always_comb begin
    if (state_r == ST_CLEAR) begin
      we_s = 1'b1;
      wa_s = cnt_r;
      wd_s = CLEAR_VALUE;
      wm_s = MASK_ALL;
    end else begin
      we_s = wr_en & wr_ready_r;
      wa_s = waddr;
      wd_s = din;
      wm_s = wr_mask;
    end
  end

  // Masked memory write; unselected lanes keep their old contents.
  always_ff @(posedge clk) begin
    if (we_s) begin
      mem_r[wa_s] <= merge_lanes(mem_r[wa_s], wd_s, wm_s);
    end else begin
      mem_r[wa_s] <= mem_r[wa_s];
    end
  end

  // Read word selection: on a same-address write, write-first returns the
  // merged word, read-first returns the stored (pre-write) word.
  always_comb begin
    rd_old_s = mem_r[raddr];
    if ((BYPASS != 0) && we_s && (wa_s == raddr)) begin
      rd_word_s = merge_lanes(rd_old_s, wd_s, wm_s);
    end else begin
      rd_word_s = rd_old_s;
    end
  end

  // RAM read register; data holds when no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= {DATA_WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) begin
        rd_data_r <= rd_word_s;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] out_data_r;
      logic                  out_valid_r;

      // Fabric output register behind the RAM read register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_data_r  <= {DATA_WIDTH{1'b0}};
          out_valid_r <= 1'b0;
        end else begin
          out_valid_r <= rd_valid_r;
          if (rd_valid_r) begin
            out_data_r <= rd_data_r;
          end else begin
            out_data_r <= out_data_r;
          end
        end
      end

      assign dout       = out_data_r;
      assign dout_valid = out_valid_r;
    end else begin : g_lat1
      assign dout       = rd_data_r;
      assign dout_valid = rd_valid_r;
    end
  endgenerate

endmodule
